dmem_latency_model: RTL and testbench
=====================================

# dmem_latency_model

Synthesizable, parametrised data-memory responder for the core's data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It replaces the behavioural latency counters in the simulation bench with an FSM that has independent load and store latencies, and it adds byte-lane big-endian storage. It also provides STDOUT and EXIT memory-mapped addresses, alignment and range error reporting, and a max-address tracker for memory dumps. It sits outside `top`, on the same side as the instruction memory.

## Interface
- `DATA_WIDTH`, 32, bus width; must be 32 (four byte lanes).
- `DEPTH`, 1024, storage depth in 32-bit words; byte address range is 0 to DEPTH*4-1.
- `LOAD_LAT`, 1, cycles from request acceptance to ack for loads; ≥1.
- `STORE_LAT`, 1, cycles from request acceptance to ack for stores; ≥1.
- `STDOUT_ADDR`, 32'hf0000000, byte-store character output address.
- `EXIT_ADDR`, 32'hff000000, any store here sets the exit flag.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mreq`  in  1  request valid (MREQ).
- `write`  in  1  1 = store, 0 = load (WRITE).
- `size`  in  2  00 = word, 01 = half, 10/11 = byte (SIZE).
- `addr`  in  32  byte address (DAD).
- `wdata`  in  32  store data; half uses [15:0], byte uses [7:0].
- `rdata`  out  32  load data, zero-extended; valid only while `ack_n` = 0.
- `ack_n`  out  1  active-low acknowledge (ACKD_n).
- `stdout_valid`  out  1  one-cycle pulse on a STDOUT byte store.
- `stdout_char`  out  8  character; held until the next pulse.
- `exit_o`  out  1  sticky; set by a store to EXIT_ADDR.
- `err`  out  1  one-cycle pulse, coincident with `ack_n` low, on a misaligned or out-of-range access.
- `max_addr`  out  32  highest in-range byte address accessed (load or store).

## Operation
- **FSM states:** IDLE, WAIT, ACK.
- **IDLE → acceptance:** when `mreq` = 1, the block captures `addr`, `write`, `size` and `wdata` and loads the counter with the active latency L (LOAD_LAT or STORE_LAT).
  - If L = 1, the next state is ACK.
  - Otherwise the next state is WAIT with count = L-1.
- **WAIT:** decrements the counter each cycle and moves to ACK when the counter reaches 1. Bus inputs are ignored while in WAIT.
- **ACK:** `ack_n` = 0 for exactly one cycle.
  - Stores commit, or MMIO actions fire, on the edge that enters ACK.
  - `rdata` is registered on that same edge.
  - ACK always returns to IDLE.
- **Byte order:** big-endian. The byte at address a occupies lane [31:24] of word a>>2. Half and byte loads are returned right-justified in `rdata`.
- **Alignment and range errors:**
  - Misaligned access: a word with addr[1:0] ≠ 0, or a half with addr[0] ≠ 0.
  - Out-of-range access: addr ≥ DEPTH*4 and addr is neither MMIO address.
  - Response to either: ack is still given, there is no write, `rdata` = 0, `err` pulses, and `max_addr` is unchanged.
- **MMIO stores:**
  - A byte store to STDOUT_ADDR pulses `stdout_valid` with `stdout_char` = wdata[7:0]. A non-byte store to STDOUT_ADDR raises `err`.
  - A store of any size to EXIT_ADDR sets `exit_o`.
  - Neither MMIO store touches storage or `max_addr`.
- **MMIO loads:** return 0 without `err`.
- **max_addr:** updated to the access address when the address is greater than the current value.
- **Back-to-back requests:** a request still asserted in the IDLE cycle after ACK is treated as a new request. The master must drop `mreq` on seeing ack if it does not want a repeat.

## Timing
- **Reset values:** `ack_n` = 1, `rdata` = 0, `stdout_valid` = 0, `stdout_char` = 0, `exit_o` = 0, `err` = 0, `max_addr` = 0, state = IDLE.
- **Storage and reset:** storage is not cleared by reset.
- **Latency:** a request accepted at edge N drives `ack_n` low from edge N+L-1 to edge N+L. With L = 1, `ack_n` is low from edge N to edge N+1.
- **Reset mid-operation:** reset in WAIT or ACK aborts the request. No commit occurs if reset is asserted before the commit edge. Outputs return to reset values immediately.
- **Sticky exit:** `exit_o` clears only on `rst`.

## Structure
- **Package `dmem_pkg`:**
  - size encodings: SZ_WORD, SZ_HALF, SZ_BYTE.
  - state enum: IDLE, WAIT, ACK.
  - default MMIO address constants.
- **Sub-module `dmem_byte_array`:** DEPTH × 4 byte lanes, per-lane write enable, synchronous write, combinational read.
- **Top module:** the FSM, lane steering, MMIO decode, error logic and `max_addr` tracking.

## Test plan
1. LOAD_LAT = STORE_LAT = 1: store word 32'h11223344 to addr 8, then load half at addr 10 → `rdata` = 32'h00003344, `ack_n` low exactly one cycle after each acceptance.
2. LOAD_LAT = 3, STORE_LAT = 2: load accepted at edge N acks at edge N+2; store acks at edge N+1; inputs changed during WAIT have no effect.
3. Byte stores 'H' and 'i' to STDOUT_ADDR → two `stdout_valid` pulses with 8'h48 and 8'h69; store to EXIT_ADDR → `exit_o` = 1 and stays 1 until `rst`.
4. Word load at addr 6, and byte load at DEPTH*4 → ack given, `rdata` = 0, `err` pulse, `max_addr` unchanged.
5. Assert `rst` during WAIT of a store to addr 0 → `ack_n` stays 1, memory word 0 unchanged; then a new load of addr 0 completes normally.
6. Accesses to addresses 4, 100, 40 → `max_addr` = 100.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory latency model.
//   - SZ_* : bus SIZE encodings (10 and 11 both mean byte)
//   - DEF_STDOUT_ADDR / DEF_EXIT_ADDR : default memory-mapped I/O addresses
//   - state_e : responder FSM states
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] DEF_STDOUT_ADDR = 32'hf000_0000;
  localparam logic [31:0] DEF_EXIT_ADDR   = 32'hff00_0000;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_e;

endpackage

// File: rtl/dmem_latency_model_if.sv
// dmem_latency_model_if: core data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
//   mreq  : request valid            write : 1 = store, 0 = load
//   size  : 00 word, 01 half, 1x byte
//   addr  : byte address             wdata : store data (right-justified)
//   rdata : load data, zero-extended ack_n : active-low acknowledge
// master = core side, slave = memory side.
interface dmem_latency_model_if;
  logic        mreq;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack_n;

  modport master (
    output mreq, write, size, addr, wdata,
    input  rdata, ack_n
  );

  modport slave (
    input  mreq, write, size, addr, wdata,
    output rdata, ack_n
  );
endinterface

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: Depth words x Lanes byte lanes, per-lane write enable,
// synchronous write, combinational read. Lane Lanes-1 holds the lowest byte
// address of a word (big-endian). Not reset.
//   clk_i   : write clock
//   idx_i   : word index (shared by read and write)
//   we_i    : per-lane write enables
//   wdata_i : lane-aligned write data
//   rdata_o : word at idx_i
module dmem_byte_array #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned Lanes = 4,
  parameter int unsigned Aw    = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic               clk_i,
  input  logic [Aw-1:0]      idx_i,
  input  logic [Lanes-1:0]   we_i,
  input  logic [Lanes*8-1:0] wdata_i,
  output logic [Lanes*8-1:0] rdata_o
);

  logic [Lanes-1:0][7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Lanes; i++) begin
      if (we_i[i]) begin
        mem_q[idx_i][i] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_latency_model.sv
// dmem_latency_model: data-memory responder with independent load/store
// latency, big-endian byte-lane storage, STDOUT/EXIT MMIO, error reporting
// and a max-address tracker.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : data bus, slave side
//   stdout_valid : one-cycle pulse on a byte store to STDOUT_ADDR
//   stdout_char  : last character written to STDOUT_ADDR
//   exit_o       : sticky, set by any store to EXIT_ADDR
//   err          : pulse with ack on misaligned/out-of-range access
//   max_addr     : highest in-range byte address accessed
module dmem_latency_model
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned STORE_LAT   = 1,
  parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
  parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_latency_model_if.slave  bus,
  output logic                 stdout_valid,
  output logic [7:0]           stdout_char,
  output logic                 exit_o,
  output logic                 err,
  output logic [31:0]          max_addr
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned Aw       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] MemBytes = 32'(DEPTH * 4);
  localparam logic [15:0] LdLat    = 16'(LOAD_LAT);
  localparam logic [15:0] StLat    = 16'(STORE_LAT);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_write_q;
  logic [1:0]  req_size_q;
  logic [31:0] req_addr_q, req_wdata_q;

  logic        in_idle, enter_ack;
  logic        cur_write;
  logic [1:0]  cur_size, off;
  logic [31:0] cur_addr, cur_wdata;
  logic [15:0] lat;

  logic        is_stdout, is_exit, is_byte, misalign, out_range, acc_err, mem_ok;
  logic [3:0]  wr_be, mem_we;
  logic [31:0] wr_word, rd_word, ld_data, rd_shift;

  logic        stdout_valid_q, exit_q, err_q;
  logic [7:0]  stdout_char_q;
  logic [31:0] rdata_q, max_q;

  // With L = 1 the commit edge is also the acceptance edge, so the live bus
  // is used in IDLE and the captured request everywhere else.
  assign in_idle   = (state_q == StIdle);
  assign cur_write = in_idle ? bus.write : req_write_q;
  assign cur_size  = in_idle ? bus.size  : req_size_q;
  assign cur_addr  = in_idle ? bus.addr  : req_addr_q;
  assign cur_wdata = in_idle ? bus.wdata : req_wdata_q;
  assign off       = cur_addr[1:0];
  assign lat       = bus.write ? StLat : LdLat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    enter_ack = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.mreq) begin
          if (lat == 16'd1) begin
            state_d   = StAck;
            enter_ack = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = lat - 16'd1;
          end
        end
      end
      StWait: begin
        if (cnt_q == 16'd1) begin
          state_d   = StAck;
          enter_ack = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      req_write_q <= 1'b0;
      req_size_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && bus.mreq) begin
        req_write_q <= bus.write;
        req_size_q  <= bus.size;
        req_addr_q  <= bus.addr;
        req_wdata_q <= bus.wdata;
      end
    end
  end

  // Decode: MMIO addresses bypass range/alignment checks; only a non-byte
  // store to STDOUT is an error there.
  always_comb begin
    is_stdout = (cur_addr == STDOUT_ADDR);
    is_exit   = (cur_addr == EXIT_ADDR);
    is_byte   = |(cur_size & SZ_BYTE);
    misalign  = ((cur_size == SZ_WORD) && (off != 2'b00)) ||
                ((cur_size == SZ_HALF) && off[0]);
    out_range = (cur_addr >= MemBytes);
    if (is_stdout || is_exit) begin
      acc_err = cur_write && is_stdout && !is_byte;
      mem_ok  = 1'b0;
    end else begin
      acc_err = misalign || out_range;
      mem_ok  = !acc_err;
    end
  end

  // Big-endian lane steering: be[3] is lane [31:24], the lowest address.
  always_comb begin
    wr_be   = '0;
    wr_word = '0;
    case (cur_size)
      SZ_WORD: begin
        wr_be   = 4'b1111;
        wr_word = cur_wdata;
      end
      SZ_HALF: begin
        wr_be   = off[1] ? 4'b0011 : 4'b1100;
        wr_word = {2{cur_wdata[15:0]}};
      end
      default: begin
        wr_be   = 4'b1000 >> off;
        wr_word = {4{cur_wdata[7:0]}};
      end
    endcase
  end

  assign rd_shift = rd_word >> {~off, 3'b000};

  always_comb begin
    ld_data = '0;
    case (cur_size)
      SZ_WORD: ld_data = rd_word;
      SZ_HALF: ld_data = off[1] ? {16'h0, rd_word[15:0]} : {16'h0, rd_word[31:16]};
      default: ld_data = {24'h0, rd_shift[7:0]};
    endcase
  end

  // rst gates the write so a reset held over the commit edge cannot commit.
  assign mem_we = (enter_ack && cur_write && mem_ok && !rst) ? wr_be : 4'b0000;

  dmem_byte_array #(
    .Depth (DEPTH),
    .Lanes (NumLanes),
    .Aw    (Aw)
  ) u_byte_array (
    .clk_i   (clk),
    .idx_i   (cur_addr[Aw+1:2]),
    .we_i    (mem_we),
    .wdata_i (wr_word),
    .rdata_o (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stdout_valid_q <= 1'b0;
      stdout_char_q  <= '0;
      exit_q         <= 1'b0;
      err_q          <= 1'b0;
      rdata_q        <= '0;
      max_q          <= '0;
    end else begin
      err_q          <= enter_ack && acc_err;
      stdout_valid_q <= enter_ack && cur_write && is_stdout && is_byte;
      if (enter_ack && cur_write && is_stdout && is_byte) begin
        stdout_char_q <= cur_wdata[7:0];
      end
      if (enter_ack && cur_write && is_exit) begin
        exit_q <= 1'b1;
      end
      if (enter_ack) begin
        rdata_q <= (!cur_write && mem_ok) ? ld_data : 32'h0;
      end
      if (enter_ack && mem_ok && (cur_addr > max_q)) begin
        max_q <= cur_addr;
      end
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ack_n    = (state_q != StAck);
  assign stdout_valid = stdout_valid_q;
  assign stdout_char  = stdout_char_q;
  assign exit_o       = exit_q;
  assign err          = err_q;
  assign max_addr     = max_q;

endmodule

// File: tb/tb_dmem_latency_model.sv
// tb_dmem_latency_model: two responders (latency 1/1 and load 3 / store 2)
// share one set of stimulus signals; `sel` routes mreq and observation to one
// of them. Expected results come from a byte-addressed memory model per DUT.
module tb_dmem_latency_model;
  import dmem_pkg::*;

  localparam int unsigned Depth    = 32;
  localparam int unsigned MemBytes = Depth * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mreq = 1'b0;
  logic        write = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem_m [2][MemBytes];
  logic [31:0] max_m [2];
  logic        exit_m [2];
  logic [7:0]  char_m [2];
  logic [31:0] last_rdata;

  dmem_latency_model_if bus0 ();
  dmem_latency_model_if bus1 ();

  assign bus0.mreq  = mreq & ~sel;
  assign bus1.mreq  = mreq & sel;
  assign bus0.write = write;
  assign bus1.write = write;
  assign bus0.size  = size;
  assign bus1.size  = size;
  assign bus0.addr  = addr;
  assign bus1.addr  = addr;
  assign bus0.wdata = wdata;
  assign bus1.wdata = wdata;

  logic        sv0, sv1, ex0, ex1, er0, er1;
  logic [7:0]  ch0, ch1;
  logic [31:0] mx0, mx1;

  dmem_latency_model #(
    .DEPTH     (Depth),
    .LOAD_LAT  (1),
    .STORE_LAT (1)
  ) u_dut0 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus0),
    .stdout_valid (sv0),
    .stdout_char  (ch0),
    .exit_o       (ex0),
    .err          (er0),
    .max_addr     (mx0)
  );

  dmem_latency_model #(
    .DEPTH     (Depth),
    .LOAD_LAT  (3),
    .STORE_LAT (2)
  ) u_dut1 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus1),
    .stdout_valid (sv1),
    .stdout_char  (ch1),
    .exit_o       (ex1),
    .err          (er1),
    .max_addr     (mx1)
  );

  logic        ack_w, sv_w, ex_w, er_w;
  logic [7:0]  ch_w;
  logic [31:0] rd_w, mx_w;

  assign ack_w = sel ? bus1.ack_n : bus0.ack_n;
  assign rd_w  = sel ? bus1.rdata : bus0.rdata;
  assign sv_w  = sel ? sv1 : sv0;
  assign ch_w  = sel ? ch1 : ch0;
  assign ex_w  = sel ? ex1 : ex0;
  assign er_w  = sel ? er1 : er0;
  assign mx_w  = sel ? mx1 : mx0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d t=%0t): got %h, expected %h", tag, sel, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      max_m[s]  = '0;
      exit_m[s] = 1'b0;
      char_m[s] = '0;
    end
  endtask

  task automatic check_reset(input int s);
    sel = (s != 0);
    #1;
    check_eq("rst_ack_n", ack_w, 1);
    check_eq("rst_rdata", rd_w, 0);
    check_eq("rst_stdout_valid", sv_w, 0);
    check_eq("rst_stdout_char", ch_w, 0);
    check_eq("rst_exit", ex_w, 0);
    check_eq("rst_err", er_w, 0);
    check_eq("rst_max_addr", mx_w, 0);
  endtask

  // One transaction: the model is updated first, then the DUT is checked on
  // each falling edge through the expected ack and one cycle beyond.
  task automatic access(input int s, input logic wr, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
    int          lat, nb;
    logic        e_err, e_pulse;
    logic [31:0] e_rd;
    lat     = wr ? ((s != 0) ? 2 : 1) : ((s != 0) ? 3 : 1);
    e_err   = 1'b0;
    e_pulse = 1'b0;
    e_rd    = '0;
    if (a == DEF_STDOUT_ADDR || a == DEF_EXIT_ADDR) begin
      if (wr && a == DEF_STDOUT_ADDR) begin
        if (sz >= 2'd2) begin
          e_pulse   = 1'b1;
          char_m[s] = wd[7:0];
        end else begin
          e_err = 1'b1;
        end
      end
      if (wr && a == DEF_EXIT_ADDR) exit_m[s] = 1'b1;
    end else begin
      nb    = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
      e_err = ((a % nb) != 0) || (a >= MemBytes);
      if (!e_err) begin
        for (int b = 0; b < nb; b++) begin
          if (wr) mem_m[s][a+b] = wd[8*(nb-1-b) +: 8];
          else    e_rd = (e_rd << 8) | 32'(mem_m[s][a+b]);
        end
        if (a > max_m[s]) max_m[s] = a;
      end
    end

    @(negedge clk);
    sel = (s != 0);
    write = wr;
    size  = sz;
    addr  = a;
    wdata = wd;
    mreq  = 1'b1;
    @(posedge clk);
    #1;
    mreq  = 1'b0;
    write = 1'($urandom());
    size  = 2'($urandom());
    addr  = $urandom();
    wdata = $urandom();
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      if (i < lat) begin
        check_eq("ack_early", ack_w, 1);
      end else if (i == lat) begin
        check_eq("ack_low", ack_w, 0);
        if (!wr || e_err) check_eq("rdata", rd_w, e_rd);
        check_eq("err", er_w, e_err);
        check_eq("stdout_valid", sv_w, e_pulse);
        check_eq("stdout_char", ch_w, char_m[s]);
        check_eq("exit", ex_w, exit_m[s]);
        check_eq("max_addr", mx_w, max_m[s]);
        last_rdata = rd_w;
      end else begin
        check_eq("ack_release", ack_w, 1);
        check_eq("err_pulse_end", er_w, 0);
        check_eq("stdout_pulse_end", sv_w, 0);
      end
    end
  endtask

  // Store to addr 0 on dut1 (store latency 2), reset asserted in WAIT and
  // held across the would-be commit edge.
  task automatic reset_during_wait();
    @(negedge clk);
    sel   = 1'b1;
    write = 1'b1;
    size  = SZ_WORD;
    addr  = 32'h0;
    wdata = 32'hdead_beef;
    mreq  = 1'b1;
    @(posedge clk);
    #1 mreq = 1'b0;
    #2 rst = 1'b1;
    #1 check_eq("rst_wait_ack_n", ack_w, 1);
    @(posedge clk);
    #1 check_eq("rst_commit_edge_ack_n", ack_w, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int          s;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] a;

    model_reset();
    repeat (2) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < int'(Depth); w++) access(d, 1'b1, SZ_WORD, 32'(w * 4), $urandom());
    end

    // Big-endian half load after a word store.
    access(0, 1'b1, SZ_WORD, 32'd8, 32'h1122_3344);
    access(0, 1'b0, SZ_HALF, 32'd10, 32'h0);
    check_eq("be_half_load", last_rdata, 32'h0000_3344);

    // Longer latencies on dut1.
    access(1, 1'b1, SZ_WORD, 32'd16, 32'hcafe_f00d);
    access(1, 1'b0, SZ_BYTE, 32'd17, 32'h0);
    check_eq("be_byte_load", last_rdata, 32'h0000_00fe);

    // STDOUT and EXIT.
    access(0, 1'b1, SZ_BYTE, DEF_STDOUT_ADDR, 32'h48);
    access(0, 1'b1, 2'b11, DEF_STDOUT_ADDR, 32'h69);
    check_eq("stdout_second_char", ch0, 32'h69);
    access(0, 1'b1, SZ_HALF, DEF_STDOUT_ADDR, 32'h41);
    access(0, 1'b0, SZ_WORD, DEF_STDOUT_ADDR, 32'h0);
    access(0, 1'b1, SZ_WORD, DEF_EXIT_ADDR, 32'h0);
    access(0, 1'b0, SZ_WORD, 32'd0, 32'h0);
    check_eq("exit_sticky", ex0, 1);

    // Misaligned and out-of-range.
    access(1, 1'b0, SZ_WORD, 32'd6, 32'h0);
    access(1, 1'b0, SZ_BYTE, 32'(MemBytes), 32'h0);
    access(1, 1'b1, SZ_HALF, 32'd5, 32'h1234);

    // Reset mid-operation, then storage survives and a load completes.
    reset_during_wait();
    check_reset(0);
    check_reset(1);
    access(1, 1'b0, SZ_WORD, 32'd0, 32'h0);

    // Max address tracking from a fresh reset.
    access(0, 1'b0, SZ_WORD, 32'd4, 32'h0);
    access(0, 1'b0, SZ_WORD, 32'd100, 32'h0);
    access(0, 1'b0, SZ_WORD, 32'd40, 32'h0);
    check_eq("max_addr_100", mx0, 32'd100);

    repeat (300) begin
      s  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        7:       a = 32'(MemBytes) + $urandom_range(0, 63);
        8:       a = DEF_STDOUT_ADDR;
        9:       a = DEF_EXIT_ADDR;
        default: a = $urandom_range(0, MemBytes - 1);
      endcase
      access(s, wr, sz, a, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
